coder_n_2n_pipe: RTL and testbench

CODER_N_2N_PIPE -- requirements
Module: coder_n_2n_pipe

---
 rtl/coder_pkg.sv | 16 +
 rtl/coder_skid_buf.sv | 93 +++++++++
 rtl/coder_n_2n_pipe.sv | 79 +++++++
 tb/tb_coder_n_2n_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coder_pkg.sv
// Shared definitions for the binary/one-hot coder pipeline: mode constants,
// result-buffer state encoding and the error-counter width.
package coder_pkg;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_ENC = 1'b1;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage : coder_pkg

// File: rtl/coder_skid_buf.sv
// Two-entry in-order result buffer. in_ready and out_valid come straight from
// the state register, so neither handshake has a combinational path through it.
module coder_skid_buf
  import coder_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] head_q, tail_q;
  logic         acc, xfer;
  logic         load_head, load_tail, shift;

  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        unique case ({acc, xfer})
          2'b10: begin
            state_d   = FULL;
            load_tail = 1'b1;
          end
          2'b01:   state_d   = EMPTY;
          2'b11:   load_head = 1'b1;
          default: state_d   = ONE;
        endcase
      end
      FULL: begin
        // in_ready is low here, so only a transfer can happen.
        if (xfer) begin
          state_d = ONE;
          shift   = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: both entries are reset; the storage is tiny and a cleared head is
  // what makes out_data read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= in_data;
      end else if (shift) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= in_data;
      end
    end
  end

endmodule : coder_skid_buf

// File: rtl/coder_n_2n_pipe.sv
// Binary <-> one-hot coder with a valid/ready pipeline and 2-entry result
// buffer. Define CODER_ERR_CNT_EN to add the saturating err_cnt output.
module coder_n_2n_pipe
  import coder_pkg::*;
#(
  parameter  int IDX_W = 3,
  localparam int OH_W  = 2 ** IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [OH_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OH_W-1:0]      out_data,
`ifdef CODER_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic                 out_err
);

  logic [OH_W-1:0]  dec_data;
  logic             dec_err;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_err;
  logic [OH_W:0]    res_payload;
  logic [OH_W:0]    buf_payload;

  always_comb begin
    dec_data = OH_W'(1) << in_data[IDX_W-1:0];
    dec_err  = |in_data[OH_W-1:IDX_W];

    // Scanning downward lets the lowest set bit win on multi-hot inputs.
    enc_idx = '0;
    for (int i = OH_W - 1; i >= 0; i--) begin
      if (in_data[i]) enc_idx = IDX_W'(i);
    end
    enc_err = (in_data == '0) || ((in_data & (in_data - OH_W'(1))) != '0);

    if (in_mode == MODE_ENC) begin
      res_payload = {enc_err, OH_W'(enc_idx)};
    end else begin
      res_payload = {dec_err, dec_data};
    end
  end

  coder_skid_buf #(
    .W (OH_W + 1)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_payload)
  );

  assign out_err  = buf_payload[OH_W];
  assign out_data = buf_payload[OH_W-1:0];

`ifdef CODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule : coder_n_2n_pipe

// File: tb/tb_coder_n_2n_pipe.sv
// Scoreboard bench for coder_n_2n_pipe (IDX_W = 3): expected results are
// queued on accept and compared in order on each transfer.
module tb_coder_n_2n_pipe;
  import coder_pkg::*;

  localparam int IDX_W = 3;
  localparam int OH_W  = 2 ** IDX_W;

  typedef struct packed {
    logic            err;
    logic [OH_W-1:0] data;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_mode;
  logic [OH_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [OH_W-1:0] out_data;
  logic            out_err;
`ifdef CODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t pending_exp;
  int   exp_err_cnt = 0;
  logic stalled = 1'b0;
  res_t held;

  coder_n_2n_pipe #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef CODER_ERR_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic mode, input logic [OH_W-1:0] d);
    res_t r;
    r = '0;
    if (mode == MODE_DEC) begin
      r.data = OH_W'(1) << d[IDX_W-1:0];
      r.err  = |d[OH_W-1:IDX_W];
    end else begin
      r.err = (d == '0) || ((d & (d - OH_W'(1))) != '0);
      for (int k = 0; k < OH_W; k++) begin
        if (d[k]) begin
          r.data = OH_W'(k);
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic drive(input logic mode, input logic [OH_W-1:0] d, input res_t exp);
    in_valid    = 1'b1;
    in_mode     = mode;
    in_data     = d;
    pending_exp = exp;
  endtask

  // Called just after a falling edge with inputs settled: resolves the
  // handshakes of the coming rising edge, then advances one cycle.
  task automatic cycle();
    res_t e;
    if (stalled && out_valid) begin
      check("stall_data", out_data, held.data);
      check("stall_err", out_err, held.err);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_err", out_err, e.err);
        if (e.err && exp_err_cnt < 16'hFFFF) exp_err_cnt++;
      end
    end
    stalled = out_valid && !out_ready;
    held    = '{err: out_err, data: out_data};
    if (in_valid && in_ready) sb.push_back(pending_exp);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = MODE_DEC;
    in_data   = '0;
    out_ready = 1'b0;
    pending_exp = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_err", out_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", out_valid, 1'b0);

    // Decode sweep, back-to-back with latency 1.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(MODE_DEC, OH_W'(i), '{err: 1'b0, data: OH_W'(1) << i});
      cycle();
      check("dec_lat_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    cycle();
    check("dec_done_valid", out_valid, 1'b0);
    check("dec_done_queue", sb.size(), 0);

    // Directed decode-error and encode cases.
    drive(MODE_DEC, 8'h0A, '{err: 1'b1, data: 8'h04}); cycle();
    drive(MODE_ENC, 8'h20, '{err: 1'b0, data: 8'h05}); cycle();
    drive(MODE_ENC, 8'h00, '{err: 1'b1, data: 8'h00}); cycle();
    drive(MODE_ENC, 8'h12, '{err: 1'b1, data: 8'h01}); cycle();
    drain();

    // Backpressure: two accepted, third held off until the first transfer.
    out_ready = 1'b0;
    drive(MODE_DEC, 8'h01, '{err: 1'b0, data: 8'h02});
    check("bp_rdy0", in_ready, 1'b1); cycle();
    drive(MODE_DEC, 8'h02, '{err: 1'b0, data: 8'h04});
    check("bp_rdy1", in_ready, 1'b1); cycle();
    drive(MODE_DEC, 8'h03, '{err: 1'b0, data: 8'h08});
    check("bp_full_rdy", in_ready, 1'b0); cycle();
    check("bp_hold_rdy", in_ready, 1'b0);
    check("bp_hold_data", out_data, 8'h02);
    out_ready = 1'b1;
    cycle();
    check("bp_rdy_after_xfer", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("bp_third_valid", out_valid, 1'b1);
    cycle();
    check("bp_empty", out_valid, 1'b0);
    check("bp_queue", sb.size(), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      logic            m;
      logic [OH_W-1:0] d;
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       d = OH_W'(1) << $urandom_range(0, OH_W - 1);
        1:       d = '0;
        default: d = OH_W'($urandom);
      endcase
      if (m == MODE_DEC && $urandom_range(0, 1) == 1) d = OH_W'($urandom_range(0, OH_W - 1));
      if ($urandom_range(0, 3) != 0) drive(m, d, model(m, d));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

`ifdef CODER_ERR_CNT_EN
    check("err_cnt_val", err_cnt, 16'(exp_err_cnt));
`endif

    // Reset while the buffer is full.
    out_ready = 1'b0;
    drive(MODE_DEC, 8'h05, '{err: 1'b0, data: 8'h20}); cycle();
    drive(MODE_DEC, 8'h06, '{err: 1'b0, data: 8'h40}); cycle();
    in_valid = 1'b0;
    check("pre_rst_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_err", out_err, 1'b0);
    sb.delete();
    exp_err_cnt = 0;
    stalled = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_rdy", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("post_rst_stale", out_valid, 1'b0);
    end

`ifdef CODER_ERR_CNT_EN
    check("err_cnt_rst", err_cnt, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      drive(MODE_ENC, 8'h00, '{err: 1'b1, data: 8'h00});
      cycle();
    end
    drain();
    check("err_cnt_three", err_cnt, 16'd3);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt_q;
    drive(MODE_DEC, 8'hF0, '{err: 1'b1, data: 8'h01}); cycle();
    drain();
    check("err_cnt_sat", err_cnt, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute backstop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_coder_n_2n_pipe
